// File: rtl/pipelined_addsub_unit.sv
// Pipelined add/subtract unit with signed/unsigned flags, optional saturation
// and a valid/ready handshake; STAGES register slots, one op per cycle.
module pipelined_addsub_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic             op_signed,
  input  logic             op_sat,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_borrow,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             cb;
    logic             ov;
    logic             zero;
    logic             neg;
  } beat_t;

  localparam logic [WIDTH-1:0] AllOnes = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MaxPos  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MinNeg  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [STAGES-1:0] valid_q;
  beat_t             slot_q [STAGES];
  logic [STAGES-1:0] load;

  logic [WIDTH-1:0]  b_eff;
  logic [WIDTH:0]    raw;
  logic              sign_a;
  logic              sign_b;
  logic              sign_r;
  logic              cb_d;
  logic              ov_d;
  logic [WIDTH-1:0]  res_d;
  beat_t             beat_d;

  // Everything is resolved at accept time; the slots only carry the finished beat.
  always_comb begin
    b_eff  = op_sub ? ~b : b;
    raw    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op_sub};
    sign_a = a[WIDTH-1];
    sign_b = b[WIDTH-1];
    sign_r = raw[WIDTH-1];
    cb_d   = op_sub ? ~raw[WIDTH] : raw[WIDTH];
    if (op_sub) begin
      ov_d = (sign_a != sign_b) && (sign_r != sign_a);
    end else begin
      ov_d = (sign_a == sign_b) && (sign_r != sign_a);
    end

    res_d = raw[WIDTH-1:0];
    if (op_sat) begin
      if (op_signed) begin
        if (ov_d) begin
          res_d = sign_a ? MinNeg : MaxPos;
        end
      end else if (cb_d) begin
        res_d = op_sub ? '0 : AllOnes;
      end
    end

    beat_d.res  = res_d;
    beat_d.cb   = cb_d;
    beat_d.ov   = ov_d;
    beat_d.zero = (res_d == '0);
    beat_d.neg  = res_d[WIDTH-1];
  end

  // A slot may load when it, or any slot downstream of it, is empty, or the sink is ready.
  always_comb begin
    logic room;
    load = '0;
    room = out_ready;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      room    = room | ~valid_q[i];
      load[i] = room;
    end
  end

  assign in_ready = load[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(STAGES); i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      if (load[0]) begin
        valid_q[0] <= in_valid;
        if (in_valid) begin
          slot_q[0] <= beat_d;
        end
      end
      for (int i = 1; i < int'(STAGES); i++) begin
        if (load[i]) begin
          valid_q[i] <= valid_q[i-1];
          if (valid_q[i-1]) begin
            slot_q[i] <= slot_q[i-1];
          end
        end
      end
    end
  end

  assign out_valid    = valid_q[STAGES-1];
  assign result       = slot_q[STAGES-1].res;
  assign carry_borrow = slot_q[STAGES-1].cb;
  assign overflow     = slot_q[STAGES-1].ov;
  assign zero         = slot_q[STAGES-1].zero;
  assign negative     = slot_q[STAGES-1].neg;

endmodule

// File: tb/tb_pipelined_addsub_unit.sv
// Bench for pipelined_addsub_unit: directed cases plus random traffic, checked
// by a scoreboard fed from an integer-arithmetic reference model.
module tb_pipelined_addsub_unit;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned STAGES = 2;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic             op_signed;
  logic             op_sat;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_borrow;
  logic             overflow;
  logic             zero;
  logic             negative;

  pipelined_addsub_unit #(
    .WIDTH (WIDTH),
    .STAGES(STAGES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op_sub      (op_sub),
    .op_signed   (op_signed),
    .op_sat      (op_sat),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .carry_borrow(carry_borrow),
    .overflow    (overflow),
    .zero        (zero),
    .negative    (negative)
  );

  typedef struct {
    logic [31:0] res;
    logic        cb;
    logic        ov;
    logic        z;
    logic        n;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_acc = 0;
  bit   lat_next   = 0;
  bit   rand_ready = 0;

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: exact integer sums decide carry/borrow and overflow.
  function automatic exp_t model(input logic sub, input logic sgn, input logic sat,
                                 input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    longint      ux;
    longint      uy;
    longint      sx;
    longint      sy;
    longint      ex;
    logic [63:0] us;
    logic [31:0] r;
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    us = sub ? ux - uy : ux + uy;
    ex = sub ? sx - sy : sx + sy;
    e.cb = sub ? (ux < uy) : (us > 64'hFFFF_FFFF);
    e.ov = (ex > 64'sd2147483647) || (ex < -64'sd2147483648);
    r = us[31:0];
    if (sat) begin
      if (sgn) begin
        if (e.ov) r = (ex > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      end else if (e.cb) begin
        r = sub ? 32'h0 : 32'hFFFF_FFFF;
      end
    end
    e.res = r;
    e.z   = (r == 0);
    e.n   = r[31];
    e.acc = 0;
    e.lat = 0;
    return e;
  endfunction

  // Monitor: inputs only change just after posedge, so negedge sees what the edge will see.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (in_valid && in_ready) begin
        e     = model(op_sub, op_signed, op_sat, a, b);
        e.acc = cyc;
        e.lat = lat_next;
        q.push_back(e);
        n_acc++;
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
          e = q[0];
          chk(out_ready ? "beat" : "stalled_beat",
              64'({result, carry_borrow, overflow, zero, negative}),
              64'({e.res, e.cb, e.ov, e.z, e.n}));
          if (out_ready) begin
            if (e.lat) chk("latency", 64'(cyc - e.acc), 64'(STAGES));
            void'(q.pop_front());
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic sub, input logic sgn, input logic sat,
                      input logic [31:0] x, input logic [31:0] y);
    logic acc;
    int   k;
    in_valid  = 1;
    op_sub    = sub;
    op_signed = sgn;
    op_sat    = sat;
    a         = x;
    b         = y;
    k         = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      k++;
    end while (!acc && k < 200);
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 500) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("drain_left", 64'(q.size()), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic        sub;
    logic        sgn;
    logic        sat;
    logic [31:0] x;
    logic [31:0] y;
  } vec_t;

  vec_t dir[8] = '{
    '{1'b1, 1'b0, 1'b0, 32'd15,          32'd5},
    '{1'b1, 1'b0, 1'b0, 32'd5,           32'd15},
    '{1'b1, 1'b0, 1'b1, 32'd5,           32'd15},
    '{1'b1, 1'b1, 1'b0, 32'h8000_0000,   32'd1},
    '{1'b1, 1'b1, 1'b1, 32'h8000_0000,   32'd1},
    '{1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF,   32'd1},
    '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF,   32'd1},
    '{1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF,   32'd1}
  };

  initial begin
    rst       = 1;
    in_valid  = 0;
    op_sub    = 0;
    op_signed = 0;
    op_sat    = 0;
    a         = '0;
    b         = '0;
    out_ready = 1;

    #12;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_outputs", 64'({result, carry_borrow, overflow, zero, negative}), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    #10;
    rst = 0;
    @(posedge clk);
    #1;

    // Directed corners, one at a time through an empty pipe.
    lat_next = 1;
    foreach (dir[i]) begin
      send(dir[i].sub, dir[i].sgn, dir[i].sat, dir[i].x, dir[i].y);
      drain();
    end
    lat_next = 0;

    // Backpressure: only STAGES beats fit while the sink stalls.
    @(posedge clk);
    #1;
    out_ready = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(1'b0, 1'b0, 1'b0, 32'(100 * i), 32'(i));
      end
      begin
        int base;
        base = n_acc;
        repeat (6) @(posedge clk);
        #2;
        chk("bp_accepted", 64'(n_acc - base), 64'(STAGES));
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1;
      end
    join
    drain();

    // Asynchronous reset with two ops in flight.
    send(1'b0, 1'b0, 1'b0, 32'd7, 32'd8);
    send(1'b0, 1'b0, 1'b0, 32'd9, 32'd10);
    #2;
    rst = 1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_outputs", 64'({result, carry_borrow, overflow, zero, negative}), 64'd0);
    q.delete();
    @(posedge clk);
    #3;
    rst = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("postrst_idle", 64'(out_valid), 64'd0);
    lat_next = 1;
    send(1'b1, 1'b1, 1'b0, 32'd3, 32'd4);
    drain();
    lat_next = 0;

    // Random traffic with random gaps and random sink stalls.
    rand_ready = 1;
    for (int i = 0; i < 400; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(1'($urandom), 1'($urandom), 1'($urandom), pick(), pick());
    end
    rand_ready = 0;
    @(posedge clk);
    #2;
    out_ready = 1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
